// File: rtl/memory_backend_if.sv
// Request/response handshake and data-RAM port bundle of memory_backend.
// The slave modport is the backend; the master modport is the core/RAM side.
interface memory_backend_if #(parameter int RAM_A_WIDTH = 12);
  logic                   reqValid;
  logic                   reqReady;
  logic                   reqIsStore;
  logic [2:0]             reqFunct3;
  logic [31:0]            reqAddress;
  logic [31:0]            reqStoreData;
  logic                   respValid;
  logic                   respError;
  logic [31:0]            respLoadData;
  logic [RAM_A_WIDTH-1:0] ramWriteAddress;
  logic [31:0]            ramDataIn;
  logic                   ramWriteEnable;
  logic [RAM_A_WIDTH-1:0] ramReadAddressA;
  logic [31:0]            ramDataOutA;

  modport master (
    output reqValid, reqIsStore, reqFunct3, reqAddress, reqStoreData, ramDataOutA,
    input  reqReady, respValid, respError, respLoadData,
           ramWriteAddress, ramDataIn, ramWriteEnable, ramReadAddressA
  );

  modport slave (
    input  reqValid, reqIsStore, reqFunct3, reqAddress, reqStoreData, ramDataOutA,
    output reqReady, respValid, respError, respLoadData,
           ramWriteAddress, ramDataIn, ramWriteEnable, ramReadAddressA
  );
endinterface

// File: rtl/memory_backend.sv
// Byte-addressed load/store front end for a word-organised data RAM (RMW for sub-word stores).
// Optional JZJCOREF_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module memory_backend #(
  parameter int RAM_A_WIDTH = 12
) (
  input logic            clock,
  input logic            reset,
  memory_backend_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MERGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [2:0]             funct3_r;
  logic [1:0]             lane_r;
  logic [RAM_A_WIDTH-1:0] index_r;
  logic [15:0]            store_data_r;
  logic                   resp_valid_r;
  logic                   resp_error_r;
  logic [31:0]            resp_load_data_r;

  logic                   accept_s;
  logic                   req_error_s;
  logic                   misalign_s;
  logic                   req_is_sw_s;
  logic [RAM_A_WIDTH-1:0] req_index_s;
  logic [31:0]            merged_s;
  logic [31-RAM_A_WIDTH-2:0] unused_addr_s;

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] data,
                                              input logic is_half, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    if (is_half) begin
      if (lane[1]) begin
        r[31:16] = data;
      end else begin
        r[15:0] = data;
      end
    end else begin
      r[{lane, 3'b000} +: 8] = data[7:0];
    end
    return r;
  endfunction

  assign req_index_s   = bus.reqAddress[RAM_A_WIDTH+1:2];
  assign unused_addr_s = bus.reqAddress[31:RAM_A_WIDTH+2];
  assign bus.reqReady  = (state_r == IDLE) && reset;
  assign accept_s      = bus.reqValid && bus.reqReady;
  assign req_is_sw_s   = bus.reqIsStore && (bus.reqFunct3 == 3'b010);

`ifdef JZJCOREF_MISALIGN_TRAP_EN
  assign misalign_s = ((bus.reqFunct3[1:0] == 2'b01) && bus.reqAddress[0]) ||
                      ((bus.reqFunct3[1:0] == 2'b10) && (bus.reqAddress[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign req_error_s = !funct3_legal(bus.reqIsStore, bus.reqFunct3) || misalign_s;
  assign merged_s    = merge_store(bus.ramDataOutA, store_data_r, funct3_r[0], lane_r);

  assign bus.respValid    = resp_valid_r;
  assign bus.respError    = resp_error_r;
  assign bus.respLoadData = resp_load_data_r;

  // Next-state decode and RAM port drive; write enable is gated by reset so an aborted RMW never writes.
  always_comb begin
    next_state_s        = state_r;
    bus.ramWriteEnable  = 1'b0;
    bus.ramWriteAddress = index_r;
    bus.ramDataIn       = merged_s;
    bus.ramReadAddressA = index_r;
    case (state_r)
      IDLE: begin
        bus.ramReadAddressA = req_index_s;
        if (!accept_s) begin
          next_state_s = IDLE;
        end else if (req_error_s) begin
          next_state_s = DONE;
        end else if (!bus.reqIsStore) begin
          next_state_s = LOAD;
        end else if (req_is_sw_s) begin
          bus.ramWriteEnable  = reset;
          bus.ramWriteAddress = req_index_s;
          bus.ramDataIn       = bus.reqStoreData;
          next_state_s        = DONE;
        end else begin
          next_state_s = MERGE;
        end
      end
      LOAD: begin
        next_state_s = IDLE;
      end
      MERGE: begin
        bus.ramWriteEnable = reset;
        next_state_s       = IDLE;
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request capture on acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      funct3_r     <= 3'd0;
      lane_r       <= 2'd0;
      index_r      <= '0;
      store_data_r <= 16'd0;
    end else if (accept_s) begin
      funct3_r     <= bus.reqFunct3;
      lane_r       <= bus.reqAddress[1:0];
      index_r      <= req_index_s;
      store_data_r <= bus.reqStoreData[15:0];
    end else begin
      funct3_r     <= funct3_r;
      lane_r       <= lane_r;
      index_r      <= index_r;
      store_data_r <= store_data_r;
    end
  end

  // Response registers; SW/error responses are set on entry to DONE so the pulse lands in cycle 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_r     <= 1'b0;
      resp_error_r     <= 1'b0;
      resp_load_data_r <= 32'd0;
    end else begin
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && (req_error_s || req_is_sw_s)) begin
            resp_valid_r <= 1'b1;
            resp_error_r <= req_error_s;
          end else begin
            resp_valid_r <= 1'b0;
          end
        end
        LOAD: begin
          resp_valid_r     <= 1'b1;
          resp_load_data_r <= extract_load(bus.ramDataOutA, funct3_r, lane_r);
        end
        MERGE: begin
          resp_valid_r <= 1'b1;
        end
        default: begin
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
